// File: rtl/blob_bbox_analyzer.sv
//------------------------------------------------------------------------------
// blob_bbox_analyzer
//
// Purpose:
//   Takes the filtered binary foreground stream in raster order and collects
//   per-frame blob statistics: bounding box, foreground area and, when built
//   with BLOB_CENTROID_EN defined, the centroid. The results are published
//   once per frame and stay stable for the whole of the following frame.
//   During that frame the video output carries the binary mask with a
//   coloured rectangle drawn around the published box.
//
// Build option:
//   BLOB_CENTROID_EN - when defined, position sums are collected and a
//                      restoring sequential divider produces cent_x/cent_y.
//                      When undefined, the centroid outputs are tied to 0.
//
// Ports:
//   app_clk       video clock
//   app_rst       synchronous active-high reset
//   vid_hpos      current horizontal position
//   vid_vpos      current vertical position
//   foregnd_px    filtered foreground pixel at (vid_hpos, vid_vpos)
//   vid_data_out  24-bit RGB, mask plus bounding-box overlay, 2-cycle latency
//   bbox_x0/x1    leftmost / rightmost foreground column of last frame
//   bbox_y0/y1    top / bottom foreground row of last frame
//   bbox_area     foreground pixel count of last frame (saturating)
//   bbox_valid    last frame area reached MIN_AREA
//   frame_done    one-cycle pulse, high in the first cycle new results show
//   cent_x/cent_y centroid column / row (truncated)
//   cent_valid    centroid outputs belong to the current published frame
//------------------------------------------------------------------------------
module blob_bbox_analyzer #(
   parameter int          H_IMG_RES = 640,
   parameter int          V_IMG_RES = 480,
   parameter int          POS_W     = 11,
   parameter int          AREA_W    = 19,
   parameter int          MIN_AREA  = 16,
   parameter int          BORDER_W  = 1,
   parameter logic [23:0] BOX_COLOR = 24'hFF0000
) (
   input  logic              app_clk,
   input  logic              app_rst,
   input  logic [POS_W-1:0]  vid_hpos,
   input  logic [POS_W-1:0]  vid_vpos,
   input  logic              foregnd_px,
   output logic [23:0]       vid_data_out,
   output logic [POS_W-1:0]  bbox_x0,
   output logic [POS_W-1:0]  bbox_x1,
   output logic [POS_W-1:0]  bbox_y0,
   output logic [POS_W-1:0]  bbox_y1,
   output logic [AREA_W-1:0] bbox_area,
   output logic              bbox_valid,
   output logic              frame_done,
   output logic [POS_W-1:0]  cent_x,
   output logic [POS_W-1:0]  cent_y,
   output logic              cent_valid
);

   localparam logic [POS_W-1:0]  H_LAST   = POS_W'(H_IMG_RES - 1);
   localparam logic [POS_W-1:0]  V_LAST   = POS_W'(V_IMG_RES - 1);
   localparam logic [AREA_W-1:0] AREA_MIN = AREA_W'(MIN_AREA);
   localparam logic [POS_W:0]    BORDER   = (POS_W+1)'(BORDER_W);

   typedef enum logic [1:0] {
      WAIT_SOF,
      ACCUM,
      LATCH,
      DIVIDE
   } state_t;

   state_t state;

   logic [POS_W-1:0]  acc_min_x;
   logic [POS_W-1:0]  acc_max_x;
   logic [POS_W-1:0]  acc_min_y;
   logic [POS_W-1:0]  acc_max_y;
   logic [AREA_W-1:0] acc_area;

   logic px_active;
   logic px_sof;
   logic px_last;
   logic px_take;

   // Classify the current position. A pixel is taken into the accumulators
   // only when it is active foreground and we are inside a frame, which
   // includes the start-of-frame pixel itself while still in WAIT_SOF.
   always_comb begin
      px_active = (vid_hpos <= H_LAST) && (vid_vpos <= V_LAST);
      px_sof    = (vid_hpos == '0) && (vid_vpos == '0);
      px_last   = (vid_hpos == H_LAST) && (vid_vpos == V_LAST);
      px_take   = foregnd_px && px_active &&
                  ((state == ACCUM) || ((state == WAIT_SOF) && px_sof));
   end

`ifdef BLOB_CENTROID_EN
   logic [31:0] acc_sum_x;
   logic [31:0] acc_sum_y;
   logic [31:0] div_sum_y;
   logic [31:0] div_quo;
   logic [31:0] div_rem;
   logic [32:0] div_den;
   logic [5:0]  div_cnt;
   logic [32:0] div_shift;
   logic [32:0] div_trial;
   logic [31:0] div_quo_next;
   logic [31:0] div_rem_next;

   // One restoring-division step. The quotient register starts out holding
   // the dividend and shifts its top bit into the partial remainder each
   // cycle; the vacated low bit receives the new quotient bit. The remainder
   // always stays below the divisor, so bit 32 of the trial difference is a
   // reliable borrow flag.
   always_comb begin
      div_shift = {div_rem, div_quo[31]};
      div_trial = div_shift - div_den;
      if (!div_trial[32]) begin
         div_rem_next = div_trial[31:0];
         div_quo_next = {div_quo[30:0], 1'b1};
      end else begin
         div_rem_next = div_shift[31:0];
         div_quo_next = {div_quo[30:0], 1'b0};
      end
   end
`else
   // Without the centroid option there is nothing to compute, so the
   // centroid outputs are simply held at zero.
   assign cent_x     = '0;
   assign cent_y     = '0;
   assign cent_valid = 1'b0;
`endif

   // Frame state machine, accumulators and published result registers.
   // Accumulators collect min/max position and a saturating pixel count
   // while a frame is in progress. The cycle after the last active pixel is
   // the LATCH state, which copies everything into the published registers,
   // pulses frame_done with the new values and rearms the accumulators.
   // LATCH wins over a coinciding start of frame; that frame is then skipped
   // because we only leave WAIT_SOF on the next (0,0). With the centroid
   // option, LATCH hands sums and area to the divider, which runs x then y
   // for 32 steps each before returning to WAIT_SOF.
   always_ff @(posedge app_clk) begin
      if (app_rst) begin
         state      <= WAIT_SOF;
         acc_min_x  <= H_LAST;
         acc_max_x  <= '0;
         acc_min_y  <= V_LAST;
         acc_max_y  <= '0;
         acc_area   <= '0;
         bbox_x0    <= '0;
         bbox_x1    <= '0;
         bbox_y0    <= '0;
         bbox_y1    <= '0;
         bbox_area  <= '0;
         bbox_valid <= 1'b0;
         frame_done <= 1'b0;
`ifdef BLOB_CENTROID_EN
         acc_sum_x  <= '0;
         acc_sum_y  <= '0;
         div_sum_y  <= '0;
         div_quo    <= '0;
         div_rem    <= '0;
         div_den    <= '0;
         div_cnt    <= '0;
         cent_x     <= '0;
         cent_y     <= '0;
         cent_valid <= 1'b0;
`endif
      end else begin
         frame_done <= 1'b0;

         if (px_take) begin
            if (vid_hpos < acc_min_x) acc_min_x <= vid_hpos;
            if (vid_hpos > acc_max_x) acc_max_x <= vid_hpos;
            if (vid_vpos < acc_min_y) acc_min_y <= vid_vpos;
            if (vid_vpos > acc_max_y) acc_max_y <= vid_vpos;
            if (acc_area != '1) acc_area <= acc_area + 1'b1;
`ifdef BLOB_CENTROID_EN
            acc_sum_x <= acc_sum_x + 32'(vid_hpos);
            acc_sum_y <= acc_sum_y + 32'(vid_vpos);
`endif
         end

         case (state)
            WAIT_SOF: begin
               if (px_sof) state <= ACCUM;
            end

            ACCUM: begin
               if (px_last) state <= LATCH;
            end

            LATCH: begin
               bbox_x0    <= acc_min_x;
               bbox_x1    <= acc_max_x;
               bbox_y0    <= acc_min_y;
               bbox_y1    <= acc_max_y;
               bbox_area  <= acc_area;
               bbox_valid <= (acc_area >= AREA_MIN) && (acc_area != '0);
               frame_done <= 1'b1;
               acc_min_x  <= H_LAST;
               acc_max_x  <= '0;
               acc_min_y  <= V_LAST;
               acc_max_y  <= '0;
               acc_area   <= '0;
`ifdef BLOB_CENTROID_EN
               acc_sum_x  <= '0;
               acc_sum_y  <= '0;
               cent_valid <= 1'b0;
               div_quo    <= acc_sum_x;
               div_sum_y  <= acc_sum_y;
               div_rem    <= '0;
               div_den    <= 33'(acc_area);
               div_cnt    <= '0;
               state      <= (acc_area != '0) ? DIVIDE : WAIT_SOF;
`else
               state      <= WAIT_SOF;
`endif
            end

            DIVIDE: begin
`ifdef BLOB_CENTROID_EN
               div_quo <= div_quo_next;
               div_rem <= div_rem_next;
               div_cnt <= div_cnt + 1'b1;
               if (div_cnt == 6'd31) begin
                  cent_x  <= div_quo_next[POS_W-1:0];
                  div_quo <= div_sum_y;
                  div_rem <= '0;
               end
               if (div_cnt == 6'd63) begin
                  cent_y     <= div_quo_next[POS_W-1:0];
                  cent_valid <= bbox_valid;
                  state      <= WAIT_SOF;
               end
`else
               state <= WAIT_SOF;
`endif
            end

            default: state <= WAIT_SOF;
         endcase
      end
   end

   logic [POS_W:0] ov_h;
   logic [POS_W:0] ov_v;
   logic           ov_inside;
   logic           ov_edge;
   logic           ov_border;

   // Decide whether the current position lies on the overlay rectangle drawn
   // from the published box. Positions are widened by one bit so adding the
   // border thickness can never wrap. "Near the right edge" is written as
   // h + BORDER > x1 rather than h > x1 - BORDER to avoid underflow when the
   // box hugs column 0.
   always_comb begin
      ov_h      = {1'b0, vid_hpos};
      ov_v      = {1'b0, vid_vpos};
      ov_inside = (vid_hpos >= bbox_x0) && (vid_hpos <= bbox_x1) &&
                  (vid_vpos >= bbox_y0) && (vid_vpos <= bbox_y1);
      ov_edge   = (ov_h < ({1'b0, bbox_x0} + BORDER)) ||
                  ((ov_h + BORDER) > {1'b0, bbox_x1}) ||
                  (ov_v < ({1'b0, bbox_y0} + BORDER)) ||
                  ((ov_v + BORDER) > {1'b0, bbox_y1});
      ov_border = bbox_valid && ov_inside && ov_edge;
   end

   logic st_active;
   logic st_fg;
   logic st_border;

   // Two-stage output pipeline: the first stage registers the compare
   // results, the second turns them into the RGB word. Blanking positions
   // are forced to black so stray foreground bits there never leak out.
   always_ff @(posedge app_clk) begin
      if (app_rst) begin
         st_active    <= 1'b0;
         st_fg        <= 1'b0;
         st_border    <= 1'b0;
         vid_data_out <= '0;
      end else begin
         st_active <= px_active;
         st_fg     <= foregnd_px;
         st_border <= ov_border;
         if (!st_active)
            vid_data_out <= '0;
         else if (st_border)
            vid_data_out <= BOX_COLOR;
         else
            vid_data_out <= {24{st_fg}};
      end
   end

endmodule

// File: tb/tb_blob_bbox_analyzer.sv
//------------------------------------------------------------------------------
// tb_blob_bbox_analyzer
//
// Purpose:
//   Self-checking bench for blob_bbox_analyzer on a reduced 48x32 raster with
//   blanking. Each frame's mask is built from directed shapes or $urandom
//   patterns; a reference model computes frame statistics from the whole
//   mask with plain loops and predicts overlay colours from the rectangle
//   rule. Every cycle the video output, frame_done pulse and (on result
//   cycles) the published statistics are compared against that model.
//   Builds with or without BLOB_CENTROID_EN.
//------------------------------------------------------------------------------
module tb_blob_bbox_analyzer;

   localparam int          H_IMG    = 48;
   localparam int          V_IMG    = 32;
   localparam int          H_TOT    = 54;
   localparam int          V_TOT    = 35;
   localparam int          POS_W    = 11;
   localparam int          AREA_W   = 10;
   localparam int          MIN_AREA = 16;
   localparam int          BORDER_W = 2;
   localparam logic [23:0] BOX      = 24'hFF0000;
   localparam int          AREA_MAX = (1 << AREA_W) - 1;

   typedef struct {
      int x0;
      int x1;
      int y0;
      int y1;
      int area;
      int sx;
      int sy;
      bit valid;
   } stats_t;

   logic              app_clk = 1'b0;
   logic              app_rst = 1'b1;
   logic [POS_W-1:0]  vid_hpos = POS_W'(H_TOT - 1);
   logic [POS_W-1:0]  vid_vpos = POS_W'(V_TOT - 1);
   logic              foregnd_px = 1'b0;
   logic [23:0]       vid_data_out;
   logic [POS_W-1:0]  bbox_x0;
   logic [POS_W-1:0]  bbox_x1;
   logic [POS_W-1:0]  bbox_y0;
   logic [POS_W-1:0]  bbox_y1;
   logic [AREA_W-1:0] bbox_area;
   logic              bbox_valid;
   logic              frame_done;
   logic [POS_W-1:0]  cent_x;
   logic [POS_W-1:0]  cent_y;
   logic              cent_valid;

   int     total = 0;
   int     bad = 0;
   int     step = 0;
   int     latch_step = 0;
   int     cent_step = 0;
   bit     latch_pending = 1'b0;
   bit     cent_pending = 1'b0;
   bit     frame_live = 1'b0;
   bit     rst_prev = 1'b1;
   logic [23:0] e1 = 24'h0;
   logic [23:0] e2 = 24'h0;
   stats_t pub;
   stats_t pend;
   bit     mask [0:V_IMG-1][0:H_IMG-1];

   blob_bbox_analyzer #(
      .H_IMG_RES (H_IMG),
      .V_IMG_RES (V_IMG),
      .POS_W     (POS_W),
      .AREA_W    (AREA_W),
      .MIN_AREA  (MIN_AREA),
      .BORDER_W  (BORDER_W),
      .BOX_COLOR (BOX)
   ) dut (
      .app_clk      (app_clk),
      .app_rst      (app_rst),
      .vid_hpos     (vid_hpos),
      .vid_vpos     (vid_vpos),
      .foregnd_px   (foregnd_px),
      .vid_data_out (vid_data_out),
      .bbox_x0      (bbox_x0),
      .bbox_x1      (bbox_x1),
      .bbox_y0      (bbox_y0),
      .bbox_y1      (bbox_y1),
      .bbox_area    (bbox_area),
      .bbox_valid   (bbox_valid),
      .frame_done   (frame_done),
      .cent_x       (cent_x),
      .cent_y       (cent_y),
      .cent_valid   (cent_valid)
   );

   always #5 app_clk = ~app_clk;

   task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("[TB] FAIL %s at step %0d: got %0h expected %0h", tag, step, obs, exp);
      end
   endtask

   function automatic logic [23:0] expColor(input int h, input int v, input bit fg);
      bit on_box;
      if (h >= H_IMG || v >= V_IMG) return 24'h0;
      on_box = pub.valid && h >= pub.x0 && h <= pub.x1 && v >= pub.y0 && v <= pub.y1 &&
               ((h - pub.x0) < BORDER_W || (pub.x1 - h) < BORDER_W ||
                (v - pub.y0) < BORDER_W || (pub.y1 - v) < BORDER_W);
      if (on_box) return BOX;
      return fg ? 24'hFFFFFF : 24'h0;
   endfunction

   function automatic stats_t computeStats();
      stats_t s;
      int cnt;
      s = '{x0: H_IMG, x1: -1, y0: V_IMG, y1: -1, area: 0, sx: 0, sy: 0, valid: 1'b0};
      cnt = 0;
      for (int y = 0; y < V_IMG; y++)
         for (int x = 0; x < H_IMG; x++)
            if (mask[y][x]) begin
               cnt++;
               s.sx += x;
               s.sy += y;
               if (x < s.x0) s.x0 = x;
               if (x > s.x1) s.x1 = x;
               if (y < s.y0) s.y0 = y;
               if (y > s.y1) s.y1 = y;
            end
      s.area  = (cnt > AREA_MAX) ? AREA_MAX : cnt;
      s.valid = (s.area >= MIN_AREA) && (s.area != 0);
      return s;
   endfunction

   task automatic clearMask();
      for (int y = 0; y < V_IMG; y++)
         for (int x = 0; x < H_IMG; x++)
            mask[y][x] = 1'b0;
   endtask

   task automatic addRect(input int x0, input int x1, input int y0, input int y1);
      for (int y = y0; y <= y1; y++)
         for (int x = x0; x <= x1; x++)
            mask[y][x] = 1'b1;
   endtask

   task automatic addScatter(input int n);
      int placed = 0;
      int guard = 0;
      int x;
      int y;
      while (placed < n && guard < 100000) begin
         x = $urandom_range(0, H_IMG - 1);
         y = $urandom_range(0, V_IMG - 1);
         if (!mask[y][x]) begin
            mask[y][x] = 1'b1;
            placed++;
         end
         guard++;
      end
   endtask

   // One clock: check what the DUT shows after the previous edge, then drive
   // the next position. Expected video trails the driven pixel by two edges.
   task automatic stepCycle(input int h, input int v, input bit fg, input bit rst);
      @(posedge app_clk);
      #1;
      step++;
      if (rst_prev) begin
         e1 = 24'h0;
         e2 = 24'h0;
         pub = '{default: 0};
         frame_live = 1'b0;
         latch_pending = 1'b0;
         cent_pending = 1'b0;
         checkOutput("rst_bbox", {bbox_x0, bbox_x1, bbox_y0, bbox_y1, bbox_area, bbox_valid, frame_done}, 64'h0);
         checkOutput("rst_cent", {cent_x, cent_y, cent_valid}, 64'h0);
      end
      checkOutput("vid", vid_data_out, e2);
      checkOutput("frame_done", frame_done, (latch_pending && step == latch_step));
      if (latch_pending && step == latch_step) begin
         checkOutput("area", bbox_area, pend.area);
         checkOutput("valid", bbox_valid, pend.valid);
         if (pend.area != 0) begin
            checkOutput("x0", bbox_x0, pend.x0);
            checkOutput("x1", bbox_x1, pend.x1);
            checkOutput("y0", bbox_y0, pend.y0);
            checkOutput("y1", bbox_y1, pend.y1);
         end
`ifdef BLOB_CENTROID_EN
         checkOutput("cent_valid_clr", cent_valid, 64'h0);
         if (pend.area != 0) begin
            cent_pending = 1'b1;
            cent_step = step + 64;
         end
`else
         checkOutput("cent_tied", {cent_x, cent_y, cent_valid}, 64'h0);
`endif
         pub = pend;
         latch_pending = 1'b0;
      end
      if (cent_pending && step == cent_step - 1)
         checkOutput("cent_valid_early", cent_valid, 64'h0);
      if (cent_pending && step == cent_step) begin
         checkOutput("cent_valid", cent_valid, pub.valid);
         checkOutput("cent_x", cent_x, (pub.sx / pub.area) % (1 << POS_W));
         checkOutput("cent_y", cent_y, (pub.sy / pub.area) % (1 << POS_W));
         cent_pending = 1'b0;
      end

      app_rst    = rst;
      vid_hpos   = POS_W'(h);
      vid_vpos   = POS_W'(v);
      foregnd_px = fg;
      rst_prev   = rst;
      e2 = e1;
      e1 = expColor(h, v, fg);
      if (!rst && h == 0 && v == 0) frame_live = 1'b1;
      if (!rst && frame_live && h == H_IMG - 1 && v == V_IMG - 1) begin
         pend = computeStats();
         latch_pending = 1'b1;
         latch_step = step + 2;
         frame_live = 1'b0;
      end
   endtask

   // Drive one full raster of the current mask. Blanking positions carry
   // random foreground bits that must never be counted. Optionally pulse
   // reset for three cycles starting at (rst_h, rst_v).
   task automatic applyStimulus(input int rst_h, input int rst_v);
      int rst_left = 0;
      bit fg;
      for (int v = 0; v < V_TOT; v++)
         for (int h = 0; h < H_TOT; h++) begin
            if (h == rst_h && v == rst_v) rst_left = 3;
            fg = (h < H_IMG && v < V_IMG) ? mask[v][h] : 1'($urandom_range(0, 1));
            stepCycle(h, v, fg, rst_left > 0);
            if (rst_left > 0) rst_left--;
         end
   endtask

   initial begin
      int rx0;
      int rx1;
      int ry0;
      int ry1;
      pub  = '{default: 0};
      pend = '{default: 0};
      clearMask();
      repeat (4) stepCycle(H_TOT - 1, V_TOT - 1, 1'b0, 1'b1);
      stepCycle(H_TOT - 1, V_TOT - 1, 1'b0, 1'b0);

      $display("[TB] single pixel");
      clearMask(); mask[20][30] = 1'b1;
      applyStimulus(-1, -1);

      $display("[TB] rectangle");
      clearMask(); addRect(10, 29, 5, 14);
      applyStimulus(-1, -1);

      $display("[TB] corner rectangle");
      clearMask(); addRect(0, 5, 0, 3);
      applyStimulus(-1, -1);

      $display("[TB] empty frame");
      clearMask();
      applyStimulus(-1, -1);

      $display("[TB] area threshold");
      clearMask(); addScatter(10); applyStimulus(-1, -1);
      clearMask(); addScatter(15); applyStimulus(-1, -1);
      clearMask(); addScatter(16); applyStimulus(-1, -1);

      $display("[TB] full frame saturation");
      clearMask(); addRect(0, H_IMG - 1, 0, V_IMG - 1);
      applyStimulus(-1, -1);

      $display("[TB] mid-frame reset");
      clearMask(); addRect(3, 40, 2, 28);
      applyStimulus(H_IMG / 2, V_IMG / 2);
      clearMask(); addRect(5, 9, 5, 9);
      applyStimulus(-1, -1);

      $display("[TB] reset after frame end");
      clearMask(); addRect(20, 30, 10, 20);
      applyStimulus(20, V_IMG);

      $display("[TB] centroid rectangle");
      clearMask(); addRect(10, 19, 20, 29);
      applyStimulus(-1, -1);

      $display("[TB] random frames");
      repeat (5) begin
         rx0 = $urandom_range(0, H_IMG - 1);
         rx1 = $urandom_range(rx0, H_IMG - 1);
         ry0 = $urandom_range(0, V_IMG - 1);
         ry1 = $urandom_range(ry0, V_IMG - 1);
         clearMask(); addRect(rx0, rx1, ry0, ry1); addScatter($urandom_range(0, 6));
         applyStimulus(-1, -1);
      end

      clearMask();
      applyStimulus(-1, -1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/blob_bbox_analyzer.md
Name: blob_bbox_analyzer

Overview:
Parametrised successor stage to the opening filter and frame buffer in the foreground path. It consumes the filtered foreground stream in raster order and accumulates per-frame blob statistics: bounding box, area, and optionally centroid. At end of frame it publishes the results. On the following frame it drives the video output with the binary mask plus a coloured bounding-box overlay.

Parameters:
H_IMG_RES, 640, active pixels per line
V_IMG_RES, 480, active lines per frame
POS_W, 11, width of position ports and bbox coordinates
AREA_W, 19, width of area counter (must hold H_IMG_RES*V_IMG_RES)
MIN_AREA, 16, minimum foreground pixel count for a valid bbox
BORDER_W, 1, overlay rectangle line thickness in pixels
BOX_COLOR, 24'hFF0000, overlay RGB colour

Ports:
app_clk  in  1  single clock (video clock domain)
app_rst  in  1  synchronous, active-high reset
vid_hpos  in  POS_W  current horizontal position
vid_vpos  in  POS_W  current vertical position
foregnd_px  in  1  filtered foreground pixel at (vid_hpos, vid_vpos)
vid_data_out  out  24  RGB output, mask plus overlay
bbox_x0  out  POS_W  leftmost foreground column of last completed frame
bbox_x1  out  POS_W  rightmost column
bbox_y0  out  POS_W  top row
bbox_y1  out  POS_W  bottom row
bbox_area  out  AREA_W  foreground pixel count of last frame (saturating)
bbox_valid  out  1  last frame area >= MIN_AREA
frame_done  out  1  one-cycle pulse when results update
cent_x  out  POS_W  centroid column (optional feature)
cent_y  out  POS_W  centroid row (optional feature)
cent_valid  out  1  centroid outputs current (optional feature)

Behaviour:
- Clocking and reset: one clock, app_clk. Reset app_rst is synchronous and active-high.
- Reset values: all outputs 0 (vid_data_out=0, bbox_*=0, bbox_valid=0, frame_done=0, cent_*=0). FSM enters WAIT_SOF. Accumulators cleared.
- Active pixel: vid_hpos < H_IMG_RES and vid_vpos < V_IMG_RES. Inactive positions never update the accumulators.
- FSM WAIT_SOF -> ACCUM: on the cycle with vid_hpos==0 and vid_vpos==0. That pixel is accumulated in the same cycle. A partial frame after reset is discarded.
- ACCUM: for each active foreground pixel:
  - min_x = min(min_x, hpos); max_x = max(max_x, hpos); likewise for y.
  - area increments, saturating at all-ones.
  - Accumulator init values: min_x=H_IMG_RES-1, max_x=0, min_y=V_IMG_RES-1, max_y=0.
- ACCUM -> LATCH: in the cycle after the pixel at (H_IMG_RES-1, V_IMG_RES-1) is sampled.
- LATCH (1 cycle):
  - bbox_* <= accumulators; bbox_area <= area; bbox_valid <= (area >= MIN_AREA) and (area != 0).
  - frame_done=1 for that cycle.
  - Accumulators reset to init values.
  - Next state: WAIT_SOF (or DIVIDE when the optional feature is enabled).
- Empty frame: bbox_valid=0, bbox_area=0. bbox coordinates still latch the raw init values and are don't-care.
- SOF coinciding with LATCH is impossible by timing (blanking). If it occurs, LATCH takes priority and that frame is skipped.
- Overlay, using the currently published bbox registers:
  - Pixel is on the border when bbox_valid and the pixel lies within the rectangle [x0..x1]x[y0..y1] and within BORDER_W of any edge.
  - Border pixel: BOX_COLOR; otherwise {24{foregnd_px}}. Inactive positions: 0.
  - 2-cycle latency: a compare stage, then vid_data_out register.
- Published registers change only in LATCH, so the overlay never tears mid-frame.

Optional Feature:
BLOB_CENTROID_EN
- Enabled:
  - ACCUM also sums hpos and vpos of foreground pixels into 32-bit sum_x and sum_y.
  - LATCH enters state DIVIDE: a restoring sequential divider computes sum_x/area, then sum_y/area, 32 cycles each, 64 total.
  - Results (truncated) drive cent_x and cent_y; cent_valid=bbox_valid is set on the last cycle of DIVIDE; FSM then returns to WAIT_SOF.
  - cent_valid is cleared at LATCH. Area 0 skips the divide and leaves cent_valid=0.
  - A reset during DIVIDE aborts the division and clears all outputs.
- Disabled: cent_x, cent_y and cent_valid are tied to 0, with no sum or divider logic.

Test Plan:
- Reset, then a frame with a single fg pixel at (100,50) and MIN_AREA=1 -> frame_done pulses once; bbox=(100,100,50,50); area=1; valid=1.
- Rectangle fg at x 200..299, y 100..149 -> bbox=(200,299,100,149); area=5000; valid=1. On the next frame, vid_data_out=FF0000 at (200,120) and FFFFFF at (250,120), each 2 cycles after the position is presented.
- All-zero frame -> area=0, valid=0, no overlay pixels; output equals the mask.
- 10-pixel blob with MIN_AREA=16 -> area=10, valid=0, no overlay.
- Assert app_rst at (320,240) mid-frame, release -> outputs 0; the remainder of that frame is ignored; the first full frame after reset reports correctly.
- With BLOB_CENTROID_EN, rectangle x 10..19, y 20..29 -> cent_x=14, cent_y=24; cent_valid=1 within 66 cycles of frame_done.
